axis_frame_ctrl: RTL and testbench
==================================

Name: axis_frame_ctrl

Overview:
- Frame-level controller between the video-to-AXI-stream converter output and the downstream frame writer (VDMA / DDR writer).
- Arms on software command, locks onto the next start-of-frame (tuser), forwards whole frames and checks line and frame geometry against configuration.
- Discards traffic while idle or resynchronising, so the upstream FIFO is always drained.
- Adds a one-beat registered output stage and reports frame, error and count status.

Parameters:
- DWID, 16, pixel data width; tkeep width is DWID/8.
- CWID, 16, width of the geometry configuration and of all counters.

Ports:
- axis_clk  in  1  sole clock.
- reset  in  1  synchronous, active-high.
- ctrl_enable  in  1  level; 1 = run continuously; 0 = stop after the current frame.
- ctrl_oneshot  in  1  pulse; capture exactly one frame, then go IDLE.
- cfg_hpix  in  CWID  pixels per line.
- cfg_vlines  in  CWID  lines per frame.
- s_axis_tdata  in  DWID  input pixel.
- s_axis_tvalid  in  1  input valid.
- s_axis_tready  out  1  input ready; never combinationally dependent on s_axis_tvalid, tuser or tlast.
- s_axis_tuser  in  1  start of frame.
- s_axis_tlast  in  1  end of line.
- m_axis_tdata  out  DWID  registered output pixel.
- m_axis_tvalid  out  1  output valid.
- m_axis_tready  in  1  output ready.
- m_axis_tuser  out  1  output start of frame.
- m_axis_tlast  out  1  output end of line.
- m_axis_tkeep  out  DWID/8  constant all ones.
- sts_busy  out  1  1 whenever state is not IDLE.
- sts_frame_done  out  1  one-cycle pulse per completed frame.
- sts_err_line  out  1  one-cycle pulse on a short or long line.
- sts_err_frame  out  1  one-cycle pulse on an early SOF.
- sts_frame_cnt  out  CWID  count of completed frames; wraps to 0.

Behaviour:
- Single clock domain (axis_clk); reset is synchronous and active-high.
- Reset values: state IDLE; all counters 0; m_axis_tvalid, tuser and tlast 0; all sts pulses 0; sts_frame_cnt 0. A reset in mid-frame drops the held output beat on the next edge.
- Definitions:
  - acc = s_axis_tvalid && s_axis_tready.
  - slot = !m_axis_tvalid || m_axis_tready.
- s_axis_tready:
  - IDLE: 1 (discard all beats).
  - WAIT_SOF and PASS: slot.
- Output stage:
  - On a forwarded acc, load tdata/tuser/tlast and set m_axis_tvalid; latency is 1 cycle.
  - Else if m_axis_tready, clear m_axis_tvalid.
  - Hold all outputs stable while tvalid && !tready.
- State IDLE:
  - Goes to WAIT_SOF when (ctrl_enable or ctrl_oneshot) and cfg_hpix != 0 and cfg_vlines != 0.
  - ctrl_oneshot sets a oneshot flag.
  - Zero geometry keeps the block in IDLE.
- State WAIT_SOF:
  - acc with tuser=0: discard.
  - acc with tuser=1: forward the beat and latch cfg_hpix/cfg_vlines into hpix_r/vlines_r. Set pix = 1 and line = 0; if that beat also has tlast, run the tlast check below. Go to PASS.
- State PASS, on acc (all beats forwarded):
  - tuser=1 (early SOF): pulse sts_err_frame, restart counters as a new frame (pix = 1, line = 0), stay in PASS.
  - tlast=1 with pix+1 != hpix_r (short line, or long line detected at tlast): pulse sts_err_line, go to WAIT_SOF.
  - tlast=0 with pix+1 == hpix_r (long line): pulse sts_err_line, go to WAIT_SOF.
  - tlast=1, correct length, line+1 < vlines_r: line++, pix = 0.
  - tlast=1, correct length, line+1 == vlines_r: frame complete. Pulse sts_frame_done, sts_frame_cnt++. Next state:
    - IDLE if ctrl_enable == 0 or the oneshot flag is set; the oneshot flag clears.
    - Otherwise WAIT_SOF.
  - Otherwise: pix++.
- On an error, the beat that triggered it is still forwarded; the truncated frame is left to the downstream writer's tuser-based resync.
- ctrl_enable deasserted during PASS takes effect only at frame completion or on an error; on an error with enable == 0, go to IDLE instead of WAIT_SOF.
- ctrl_oneshot during PASS is ignored.
- Counters are CWID bits. Geometry is checked by exact compare; no overflow is possible, because the long-line check stops pix at hpix_r.
- Simultaneous sts_frame_done and sts_err_* cannot occur.

Decomposition:
- Shared package axis_frame_pkg: state encoding (IDLE, WAIT_SOF, PASS) and the CWID default.
- One natural sub-module: axis_reg_slice (one-entry output register with valid/ready). The FSM and counters stay in the top level.

Test Plan:
- Basic frame: cfg 4x3, enable = 1, source sends 2 garbage beats then a 4x3 frame starting with tuser, m_axis_tready = 1.
  - 2 beats discarded; 12 beats out, each 1 cycle after acceptance.
  - tuser on beat 0 only; tlast on beats 3, 7, 11.
  - sts_frame_done pulses once; sts_frame_cnt = 1.
- Oneshot: cfg 4x2, enable = 0, one ctrl_oneshot pulse, two back-to-back frames sent.
  - First frame forwarded (8 beats); block returns to IDLE.
  - Second frame fully discarded with s_axis_tready = 1; sts_busy = 0; count = 1.
- Short line: cfg 4x3, line 1 has tlast on its 3rd pixel.
  - sts_err_line pulse; remainder discarded until the next tuser.
  - Next correct frame passes; frame count increments only for that frame.
- Early SOF: cfg 4x3, tuser reasserted at line 1, pixel 2.
  - sts_err_frame pulse; counters restart.
  - A full 12-beat frame from that tuser gives sts_frame_done.
- Backpressure: m_axis_tready toggled 1-0-0-1 randomly during a 4x3 frame.
  - No beat lost or duplicated; m_axis data stable while stalled.
  - s_axis_tready = 0 exactly when m_axis_tvalid && !m_axis_tready.
- Reset mid-frame: synchronous reset at pixel 6 with m_axis_tvalid = 1 and tready = 0.
  - Next edge: m_axis_tvalid = 0, state IDLE, sts_frame_cnt = 0.
  - Block re-arms only when ctrl_enable is sampled high after reset releases.

Source files
------------

// File: rtl/axis_frame_pkg.sv
// Shared types and defaults for the AXI-stream frame controller.
package axis_frame_pkg;

    localparam int unsigned DWID_DEF = 16;
    localparam int unsigned CWID_DEF = 16;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_WAIT_SOF = 2'd1,
        ST_PASS     = 2'd2
    } state_e;

endpackage

// File: rtl/axis_reg_slice.sv
// One-entry registered output stage with valid/ready handshake.
module axis_reg_slice #(
    parameter int unsigned DWID = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            load_i,
    input  logic [DWID-1:0] tdata_i,
    input  logic            tuser_i,
    input  logic            tlast_i,
    input  logic            m_tready_i,
    output logic [DWID-1:0] m_tdata_o,
    output logic            m_tvalid_o,
    output logic            m_tuser_o,
    output logic            m_tlast_o,
    output logic            slot_c_o
);

    logic [DWID-1:0] tdata_q;
    logic            tvalid_q;
    logic            tuser_q;
    logic            tlast_q;

    // Load only happens when the slot is free, so a stalled beat is never overwritten.
    always_ff @(posedge clk) begin
        if (rst) begin
            tdata_q  <= '0;
            tvalid_q <= 1'b0;
            tuser_q  <= 1'b0;
            tlast_q  <= 1'b0;
        end else if (load_i) begin
            tdata_q  <= tdata_i;
            tvalid_q <= 1'b1;
            tuser_q  <= tuser_i;
            tlast_q  <= tlast_i;
        end else if (m_tready_i) begin
            tvalid_q <= 1'b0;
        end
    end

    assign slot_c_o   = !tvalid_q || m_tready_i;
    assign m_tdata_o  = tdata_q;
    assign m_tvalid_o = tvalid_q;
    assign m_tuser_o  = tuser_q;
    assign m_tlast_o  = tlast_q;

endmodule

// File: rtl/axis_frame_ctrl.sv
// Arms on command, locks to start-of-frame, forwards whole frames and
// checks line/frame geometry; drains the source whenever not forwarding.
module axis_frame_ctrl
    import axis_frame_pkg::*;
#(
    parameter int unsigned DWID = DWID_DEF,
    parameter int unsigned CWID = CWID_DEF
) (
    input  logic              axis_clk,
    input  logic              reset,
    input  logic              ctrl_enable,
    input  logic              ctrl_oneshot,
    input  logic [CWID-1:0]   cfg_hpix,
    input  logic [CWID-1:0]   cfg_vlines,
    input  logic [DWID-1:0]   s_axis_tdata,
    input  logic              s_axis_tvalid,
    output logic              s_axis_tready,
    input  logic              s_axis_tuser,
    input  logic              s_axis_tlast,
    output logic [DWID-1:0]   m_axis_tdata,
    output logic              m_axis_tvalid,
    input  logic              m_axis_tready,
    output logic              m_axis_tuser,
    output logic              m_axis_tlast,
    output logic [DWID/8-1:0] m_axis_tkeep,
    output logic              sts_busy,
    output logic              sts_frame_done,
    output logic              sts_err_line,
    output logic              sts_err_frame,
    output logic [CWID-1:0]   sts_frame_cnt
);

    state_e            state_q, state_d;
    logic [CWID-1:0]   pix_q, pix_d;
    logic [CWID-1:0]   line_q, line_d;
    logic [CWID-1:0]   hpix_q, hpix_d;
    logic [CWID-1:0]   vlines_q, vlines_d;
    logic [CWID-1:0]   cnt_q, cnt_d;
    logic              oneshot_q, oneshot_d;
    logic              done_q, done_d;
    logic              err_line_q, err_line_d;
    logic              err_frame_q, err_frame_d;

    logic              slot_c;
    logic              acc_c;
    logic              fwd_c;
    logic              early_sof_c;
    logic [CWID-1:0]   h_c, v_c, p_c, l_c;

    axis_reg_slice #(.DWID(DWID)) u_out (
        .clk        (axis_clk),
        .rst        (reset),
        .load_i     (fwd_c),
        .tdata_i    (s_axis_tdata),
        .tuser_i    (s_axis_tuser),
        .tlast_i    (s_axis_tlast),
        .m_tready_i (m_axis_tready),
        .m_tdata_o  (m_axis_tdata),
        .m_tvalid_o (m_axis_tvalid),
        .m_tuser_o  (m_axis_tuser),
        .m_tlast_o  (m_axis_tlast),
        .slot_c_o   (slot_c)
    );

    // State register
    always_ff @(posedge axis_clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Counters, latched geometry and status
    always_ff @(posedge axis_clk) begin
        if (reset) begin
            pix_q       <= '0;
            line_q      <= '0;
            hpix_q      <= '0;
            vlines_q    <= '0;
            cnt_q       <= '0;
            oneshot_q   <= 1'b0;
            done_q      <= 1'b0;
            err_line_q  <= 1'b0;
            err_frame_q <= 1'b0;
        end else begin
            pix_q       <= pix_d;
            line_q      <= line_d;
            hpix_q      <= hpix_d;
            vlines_q    <= vlines_d;
            cnt_q       <= cnt_d;
            oneshot_q   <= oneshot_d;
            done_q      <= done_d;
            err_line_q  <= err_line_d;
            err_frame_q <= err_frame_d;
        end
    end

    // The SOF beat in WAIT_SOF is checked against live config and zeroed position.
    assign h_c = (state_q == ST_WAIT_SOF) ? cfg_hpix   : hpix_q;
    assign v_c = (state_q == ST_WAIT_SOF) ? cfg_vlines : vlines_q;
    assign p_c = (state_q == ST_WAIT_SOF) ? '0 : pix_q;
    assign l_c = (state_q == ST_WAIT_SOF) ? '0 : line_q;

    // Next-state and counter update
    always_comb begin
        state_d     = state_q;
        pix_d       = pix_q;
        line_d      = line_q;
        hpix_d      = hpix_q;
        vlines_d    = vlines_q;
        cnt_d       = cnt_q;
        oneshot_d   = oneshot_q;
        done_d      = 1'b0;
        err_line_d  = 1'b0;
        err_frame_d = 1'b0;

        if (state_q == ST_IDLE) begin
            if ((ctrl_enable || ctrl_oneshot) && (cfg_hpix != '0) && (cfg_vlines != '0)) begin
                state_d   = ST_WAIT_SOF;
                oneshot_d = ctrl_oneshot;
            end
        end else if (fwd_c) begin
            if (early_sof_c) begin
                err_frame_d = 1'b1;
                pix_d       = CWID'(1);
                line_d      = '0;
            end else begin
                if (state_q == ST_WAIT_SOF) begin
                    hpix_d   = cfg_hpix;
                    vlines_d = cfg_vlines;
                end
                state_d = ST_PASS;
                line_d  = l_c;
                pix_d   = p_c + CWID'(1);
                if ((s_axis_tlast && (p_c + CWID'(1) != h_c)) ||
                    (!s_axis_tlast && (state_q == ST_PASS) && (p_c + CWID'(1) == h_c))) begin
                    err_line_d = 1'b1;
                    if (ctrl_enable) begin
                        state_d = ST_WAIT_SOF;
                    end else begin
                        state_d   = ST_IDLE;
                        oneshot_d = 1'b0;
                    end
                end else if (s_axis_tlast && (l_c + CWID'(1) == v_c)) begin
                    done_d = 1'b1;
                    cnt_d  = cnt_q + CWID'(1);
                    if (!ctrl_enable || oneshot_q) begin
                        state_d   = ST_IDLE;
                        oneshot_d = 1'b0;
                    end else begin
                        state_d = ST_WAIT_SOF;
                    end
                end else if (s_axis_tlast) begin
                    line_d = l_c + CWID'(1);
                    pix_d  = '0;
                end
            end
        end
    end

    // Handshake and forwarding decode
    always_comb begin
        s_axis_tready = (state_q == ST_IDLE) ? 1'b1 : slot_c;
        acc_c         = s_axis_tvalid && s_axis_tready;
        fwd_c         = acc_c && ((state_q == ST_PASS) ||
                                  ((state_q == ST_WAIT_SOF) && s_axis_tuser));
        early_sof_c   = (state_q == ST_PASS) && s_axis_tuser;
    end

    assign m_axis_tkeep   = '1;
    assign sts_busy       = (state_q != ST_IDLE);
    assign sts_frame_done = done_q;
    assign sts_err_line   = err_line_q;
    assign sts_err_frame  = err_frame_q;
    assign sts_frame_cnt  = cnt_q;

endmodule

// File: tb/tb_axis_frame_ctrl.sv
// Directed bench for axis_frame_ctrl: scoreboarded output beats and status pulses.
module tb_axis_frame_ctrl;

    localparam int unsigned DWID = 16;
    localparam int unsigned CWID = 16;

    logic              axis_clk = 1'b0;
    logic              reset = 1'b1;
    logic              ctrl_enable = 1'b0;
    logic              ctrl_oneshot = 1'b0;
    logic [CWID-1:0]   cfg_hpix = '0;
    logic [CWID-1:0]   cfg_vlines = '0;
    logic [DWID-1:0]   s_axis_tdata = '0;
    logic              s_axis_tvalid = 1'b0;
    logic              s_axis_tready;
    logic              s_axis_tuser = 1'b0;
    logic              s_axis_tlast = 1'b0;
    logic [DWID-1:0]   m_axis_tdata;
    logic              m_axis_tvalid;
    logic              m_axis_tready = 1'b1;
    logic              m_axis_tuser;
    logic              m_axis_tlast;
    logic [DWID/8-1:0] m_axis_tkeep;
    logic              sts_busy;
    logic              sts_frame_done;
    logic              sts_err_line;
    logic              sts_err_frame;
    logic [CWID-1:0]   sts_frame_cnt;

    int checks = 0;
    int failures = 0;
    int done_seen = 0;
    int err_line_seen = 0;
    int err_frame_seen = 0;
    bit bp_en = 1'b0;
    logic [DWID+1:0] exp_q[$];

    axis_frame_ctrl #(.DWID(DWID), .CWID(CWID)) dut (
        .axis_clk       (axis_clk),
        .reset          (reset),
        .ctrl_enable    (ctrl_enable),
        .ctrl_oneshot   (ctrl_oneshot),
        .cfg_hpix       (cfg_hpix),
        .cfg_vlines     (cfg_vlines),
        .s_axis_tdata   (s_axis_tdata),
        .s_axis_tvalid  (s_axis_tvalid),
        .s_axis_tready  (s_axis_tready),
        .s_axis_tuser   (s_axis_tuser),
        .s_axis_tlast   (s_axis_tlast),
        .m_axis_tdata   (m_axis_tdata),
        .m_axis_tvalid  (m_axis_tvalid),
        .m_axis_tready  (m_axis_tready),
        .m_axis_tuser   (m_axis_tuser),
        .m_axis_tlast   (m_axis_tlast),
        .m_axis_tkeep   (m_axis_tkeep),
        .sts_busy       (sts_busy),
        .sts_frame_done (sts_frame_done),
        .sts_err_line   (sts_err_line),
        .sts_err_frame  (sts_err_frame),
        .sts_frame_cnt  (sts_frame_cnt)
    );

    always #5 axis_clk = ~axis_clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge axis_clk);
            #1;
        end
    endtask

    task automatic do_reset();
        reset         = 1'b1;
        ctrl_enable   = 1'b0;
        ctrl_oneshot  = 1'b0;
        s_axis_tvalid = 1'b0;
        m_axis_tready = 1'b1;
        idle(2);
        reset = 1'b0;
        exp_q.delete();
        done_seen      = 0;
        err_line_seen  = 0;
        err_frame_seen = 0;
    endtask

    // Present one beat and hold it until the DUT accepts it.
    task automatic send(input logic [DWID-1:0] d, input logic u, input logic l, input bit fwd);
        bit ok = 1'b0;
        int n = 0;
        if (fwd) exp_q.push_back({u, l, d});
        s_axis_tdata  = d;
        s_axis_tuser  = u;
        s_axis_tlast  = l;
        s_axis_tvalid = 1'b1;
        while (!ok && n < 200) begin
            @(negedge axis_clk);
            ok = s_axis_tready;
            @(posedge axis_clk);
            #1;
            n++;
        end
        if (!ok) check_val("src_timeout", 32'd0, 32'd1);
        s_axis_tvalid = 1'b0;
    endtask

    // Beats lo..hi of a frame with h pixels per line; tuser on beat 0 when sof is set.
    task automatic send_range(input int h, input int base, input int lo, input int hi,
                              input bit fwd, input bit sof);
        for (int i = lo; i <= hi; i++) begin
            send(DWID'(base + i), sof && (i == 0), (i % h) == (h - 1), fwd);
        end
    endtask

    // Random output backpressure
    initial forever begin
        @(posedge axis_clk);
        #1;
        if (bp_en) m_axis_tready = 1'($urandom_range(0, 1));
    end

    // Output monitor: scoreboard, stall stability, ready relation, pulse counts
    initial begin
        logic            prev_stall;
        logic [DWID+1:0] prev_beat;
        logic [DWID+1:0] cur_beat;
        logic [DWID+1:0] exp_beat;
        prev_stall = 1'b0;
        prev_beat  = '0;
        forever begin
            @(negedge axis_clk);
            if (reset) begin
                prev_stall = 1'b0;
            end else begin
                cur_beat = {m_axis_tuser, m_axis_tlast, m_axis_tdata};
                if (prev_stall) check_val("stall_stable", 32'(cur_beat), 32'(prev_beat));
                if (sts_busy)
                    check_val("s_tready", 32'(s_axis_tready), 32'(!(m_axis_tvalid && !m_axis_tready)));
                if (m_axis_tvalid && m_axis_tready) begin
                    if (exp_q.size() == 0) begin
                        check_val("unexp_beat", 32'(cur_beat), 32'hFFFF_FFFF);
                    end else begin
                        exp_beat = exp_q.pop_front();
                        check_val("beat", 32'(cur_beat), 32'(exp_beat));
                    end
                end
                if (sts_frame_done) done_seen++;
                if (sts_err_line)   err_line_seen++;
                if (sts_err_frame)  err_frame_seen++;
                prev_stall = m_axis_tvalid && !m_axis_tready;
                prev_beat  = cur_beat;
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        do_reset();
        check_val("rst_tvalid", 32'(m_axis_tvalid), 32'd0);
        check_val("rst_busy", 32'(sts_busy), 32'd0);
        check_val("rst_cnt", 32'(sts_frame_cnt), 32'd0);
        check_val("rst_tready", 32'(s_axis_tready), 32'd1);
        check_val("rst_tkeep", 32'(m_axis_tkeep), 32'h3);

        // Zero geometry keeps the block idle
        ctrl_enable = 1'b1;
        cfg_hpix    = 16'd0;
        cfg_vlines  = 16'd3;
        idle(2);
        check_val("zero_geom_busy", 32'(sts_busy), 32'd0);

        // Basic 4x3 frame after two garbage beats
        do_reset();
        cfg_hpix    = 16'd4;
        cfg_vlines  = 16'd3;
        ctrl_enable = 1'b1;
        idle(1);
        check_val("basic_armed", 32'(sts_busy), 32'd1);
        send(16'hAAAA, 1'b0, 1'b0, 1'b0);
        send(16'hBBBB, 1'b0, 1'b1, 1'b0);
        check_val("basic_discard", 32'(m_axis_tvalid), 32'd0);
        send(16'h0100, 1'b1, 1'b0, 1'b1);
        check_val("basic_lat_valid", 32'(m_axis_tvalid), 32'd1);
        check_val("basic_lat_data", 32'(m_axis_tdata), 32'h0100);
        send_range(4, 'h100, 1, 11, 1'b1, 1'b1);
        idle(4);
        check_val("basic_pending", 32'(exp_q.size()), 32'd0);
        check_val("basic_done", 32'(done_seen), 32'd1);
        check_val("basic_cnt", 32'(sts_frame_cnt), 32'd1);
        check_val("basic_errs", 32'(err_line_seen + err_frame_seen), 32'd0);

        // Oneshot: first frame forwarded, second discarded
        do_reset();
        cfg_hpix     = 16'd4;
        cfg_vlines   = 16'd2;
        ctrl_oneshot = 1'b1;
        idle(1);
        ctrl_oneshot = 1'b0;
        check_val("os_armed", 32'(sts_busy), 32'd1);
        send_range(4, 'h200, 0, 7, 1'b1, 1'b1);
        check_val("os_idle_after", 32'(sts_busy), 32'd0);
        send_range(4, 'h280, 0, 7, 1'b0, 1'b1);
        check_val("os_tready", 32'(s_axis_tready), 32'd1);
        idle(3);
        check_val("os_busy", 32'(sts_busy), 32'd0);
        check_val("os_cnt", 32'(sts_frame_cnt), 32'd1);
        check_val("os_done", 32'(done_seen), 32'd1);
        check_val("os_pending", 32'(exp_q.size()), 32'd0);

        // Short line on line 1, then a good frame
        do_reset();
        cfg_hpix    = 16'd4;
        cfg_vlines  = 16'd3;
        ctrl_enable = 1'b1;
        idle(1);
        send_range(4, 'h300, 0, 3, 1'b1, 1'b1);
        send(16'h0304, 1'b0, 1'b0, 1'b1);
        send(16'h0305, 1'b0, 1'b0, 1'b1);
        send(16'h0306, 1'b0, 1'b1, 1'b1);
        send_range(4, 'h310, 0, 3, 1'b0, 1'b0);
        check_val("short_cnt_mid", 32'(sts_frame_cnt), 32'd0);
        send_range(4, 'h340, 0, 11, 1'b1, 1'b1);
        idle(4);
        check_val("short_err_line", 32'(err_line_seen), 32'd1);
        check_val("short_err_frame", 32'(err_frame_seen), 32'd0);
        check_val("short_done", 32'(done_seen), 32'd1);
        check_val("short_cnt", 32'(sts_frame_cnt), 32'd1);
        check_val("short_pending", 32'(exp_q.size()), 32'd0);

        // Early SOF at line 1 pixel 2
        do_reset();
        cfg_hpix    = 16'd4;
        cfg_vlines  = 16'd3;
        ctrl_enable = 1'b1;
        idle(1);
        send_range(4, 'h400, 0, 5, 1'b1, 1'b1);
        send_range(4, 'h440, 0, 11, 1'b1, 1'b1);
        idle(4);
        check_val("esof_err_frame", 32'(err_frame_seen), 32'd1);
        check_val("esof_err_line", 32'(err_line_seen), 32'd0);
        check_val("esof_done", 32'(done_seen), 32'd1);
        check_val("esof_cnt", 32'(sts_frame_cnt), 32'd1);
        check_val("esof_pending", 32'(exp_q.size()), 32'd0);

        // Random output backpressure over a 4x3 frame
        do_reset();
        cfg_hpix    = 16'd4;
        cfg_vlines  = 16'd3;
        ctrl_enable = 1'b1;
        idle(1);
        bp_en = 1'b1;
        send_range(4, 'h600, 0, 11, 1'b1, 1'b1);
        bp_en = 1'b0;
        idle(1);
        m_axis_tready = 1'b1;
        idle(4);
        check_val("bp_pending", 32'(exp_q.size()), 32'd0);
        check_val("bp_done", 32'(done_seen), 32'd1);
        check_val("bp_cnt", 32'(sts_frame_cnt), 32'd1);

        // Reset mid-frame with a stalled output beat
        do_reset();
        cfg_hpix    = 16'd4;
        cfg_vlines  = 16'd3;
        ctrl_enable = 1'b1;
        idle(1);
        send_range(4, 'h500, 0, 5, 1'b1, 1'b1);
        m_axis_tready = 1'b0;
        check_val("mid_held_valid", 32'(m_axis_tvalid), 32'd1);
        check_val("mid_held_data", 32'(m_axis_tdata), 32'h0505);
        reset       = 1'b1;
        ctrl_enable = 1'b0;
        idle(1);
        check_val("mid_rst_valid", 32'(m_axis_tvalid), 32'd0);
        check_val("mid_rst_busy", 32'(sts_busy), 32'd0);
        check_val("mid_rst_cnt", 32'(sts_frame_cnt), 32'd0);
        reset = 1'b0;
        exp_q.delete();
        m_axis_tready = 1'b1;
        idle(3);
        check_val("mid_stay_idle", 32'(sts_busy), 32'd0);
        ctrl_enable = 1'b1;
        idle(1);
        check_val("mid_rearm", 32'(sts_busy), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
